// File: rtl/gray_ptr_counter.sv
// Registered Gray-code FIFO pointer with up/down count, load and wrap pulse, plus a
// synchroniser and Gray-to-binary decoder for the pointer from the opposite clock domain.
module gray_ptr_counter #(
   parameter int unsigned PTR         = 3,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         CLK_50M,
   input  logic         RST,
   input  logic         en,
   input  logic         up_dn,
   input  logic         load,
   input  logic [PTR:0] load_value,
   output logic [PTR:0] bin_out,
   output logic [PTR:0] gray_out,
   output logic         wrap,
   input  logic [PTR:0] gray_in,
   output logic [PTR:0] gray_in_bin
);

   localparam logic [PTR:0] PtrOne = {{PTR{1'b0}}, 1'b1};

   logic [PTR:0] bin_q, bin_d;
   logic [PTR:0] gray_q, gray_d;
   logic         wrap_q, wrap_d;
   logic [PTR:0] sync_q [SYNC_STAGES];
   logic [PTR:0] sync_last;
   logic [PTR:0] dec_q, dec_d;

   // Load beats count; wrap only fires on a genuine count step across the endpoint.
   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (load) begin
         bin_d = load_value;
      end else if (en) begin
         if (up_dn) begin
            bin_d  = bin_q + PtrOne;
            wrap_d = &bin_q;
         end else begin
            bin_d  = bin_q - PtrOne;
            wrap_d = ~|bin_q;
         end
      end
      gray_d = bin_d ^ (bin_d >> 1);
   end

   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];

   always_comb begin
      dec_d      = '0;
      dec_d[PTR] = sync_last[PTR];
      for (int i = int'(PTR) - 1; i >= 0; i--) begin
         dec_d[i] = dec_d[i+1] ^ sync_last[i];
      end
   end

   // Plain flop chain: no logic between stages so each bit resolves metastability alone.
   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         dec_q <= '0;
      end else begin
         sync_q[0] <= gray_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         dec_q <= dec_d;
      end
   end

   assign bin_out     = bin_q;
   assign gray_out    = gray_q;
   assign wrap        = wrap_q;
   assign gray_in_bin = dec_q;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Scoreboard bench for gray_ptr_counter: expected values are queued as stimulus is
// driven and popped one cycle later when the registered outputs are sampled.
module tb_gray_ptr_counter;

   typedef struct packed {
      logic [7:0] bin;
      logic [7:0] gray;
      logic       wrap;
   } exp_t;

   typedef struct packed {
      logic [3:0] s2;
      logic [3:0] s3;
   } sync_exp_t;

   logic       clk;
   logic       rst;
   logic       en, up_dn, load;
   logic [3:0] load_value, gray_in;
   logic [3:0] bin_out, gray_out, gray_in_bin;
   logic       wrap;
   logic [3:0] s3_bin, s3_gray, s3_gin_bin;
   logic       s3_wrap;
   logic       w_en, w_up_dn, w_load;
   logic [7:0] w_load_value, w_bin, w_gray, w_gin_bin;
   logic       w_wrap;

   exp_t      sb[$];
   sync_exp_t sb_sync[$];
   int        n_cmp  = 0;
   int        n_fail = 0;

   gray_ptr_counter #(.PTR(3), .SYNC_STAGES(2)) dut (
      .CLK_50M(clk), .RST(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_value(load_value), .bin_out(bin_out), .gray_out(gray_out), .wrap(wrap),
      .gray_in(gray_in), .gray_in_bin(gray_in_bin)
   );

   gray_ptr_counter #(.PTR(3), .SYNC_STAGES(3)) dut_s3 (
      .CLK_50M(clk), .RST(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_value(load_value), .bin_out(s3_bin), .gray_out(s3_gray), .wrap(s3_wrap),
      .gray_in(gray_in), .gray_in_bin(s3_gin_bin)
   );

   gray_ptr_counter #(.PTR(7), .SYNC_STAGES(2)) dut_w (
      .CLK_50M(clk), .RST(rst), .en(w_en), .up_dn(w_up_dn), .load(w_load),
      .load_value(w_load_value), .bin_out(w_bin), .gray_out(w_gray), .wrap(w_wrap),
      .gray_in(8'h00), .gray_in_bin(w_gin_bin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pops one expected entry after an edge and checks the PTR=3 counter outputs.
   task automatic pop_check(input string name);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         n_cmp++;
         if ({4'h0, bin_out} !== e.bin) begin
            n_fail++;
            $display("FAIL %s bin: got %0d expected %0d", name, bin_out, e.bin);
         end
         n_cmp++;
         if ({4'h0, gray_out} !== e.gray) begin
            n_fail++;
            $display("FAIL %s gray: got %b expected %b", name, gray_out, e.gray[3:0]);
         end
         n_cmp++;
         if (wrap !== e.wrap) begin
            n_fail++;
            $display("FAIL %s wrap: got %b expected %b", name, wrap, e.wrap);
         end
      end
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      en   = 1'b0;
      load = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_value = '0; gray_in = '0;
      w_en = 1'b0; w_up_dn = 1'b1; w_load = 1'b0; w_load_value = '0;
      #1 rst = 1'b1;
      #2;
      n_cmp++;
      if ({bin_out, gray_out, wrap, gray_in_bin} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_async: got %h expected 0", {bin_out, gray_out, wrap, gray_in_bin});
      end
      en = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bin_out, gray_out, wrap, w_bin, w_gray} !== 25'h0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h expected 0", {bin_out, gray_out, wrap, w_bin, w_gray});
      end
      rst = 1'b0;
      en  = 1'b0;
   endtask

   task automatic test_count_up();
      logic [3:0] tbl [17];
      logic [3:0] prev, diff;
      tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
              4'b0000};
      prev  = 4'b0000;
      en    = 1'b1;
      up_dn = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         sb.push_back('{bin: 8'(k % 16), gray: {4'h0, tbl[k]}, wrap: (k == 16)});
         pop_check($sformatf("count_up[%0d]", k));
         diff = gray_out ^ prev;
         n_cmp++;
         if ($countones(diff) !== 1) begin
            n_fail++;
            $display("FAIL one_bit_step[%0d]: got %0d bits changed expected 1", k,
                     $countones(diff));
         end
         prev = gray_out;
      end
      en = 1'b0;
   endtask

   task automatic test_count_down();
      do_reset();
      en    = 1'b1;
      up_dn = 1'b0;
      sb.push_back('{bin: 8'd15, gray: 8'b1000, wrap: 1'b1});
      pop_check("down_underflow");
      sb.push_back('{bin: 8'd14, gray: 8'b1001, wrap: 1'b0});
      pop_check("down_14");
      sb.push_back('{bin: 8'd13, gray: 8'b1011, wrap: 1'b0});
      pop_check("down_13");
      en = 1'b0;
   endtask

   task automatic test_load_hold();
      load = 1'b1; load_value = 4'd9; en = 1'b1; up_dn = 1'b1;
      sb.push_back('{bin: 8'd9, gray: 8'b1101, wrap: 1'b0});
      pop_check("load_over_en");
      load = 1'b0; en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         sb.push_back('{bin: 8'd9, gray: 8'b1101, wrap: 1'b0});
         pop_check($sformatf("hold[%0d]", k));
      end
      load = 1'b1; load_value = 4'd15; en = 1'b1; up_dn = 1'b1;
      sb.push_back('{bin: 8'd15, gray: 8'b1000, wrap: 1'b0});
      pop_check("load_all_ones");
      load_value = 4'd0; up_dn = 1'b0;
      sb.push_back('{bin: 8'd0, gray: 8'b0000, wrap: 1'b0});
      pop_check("load_zero");
      load = 1'b0; en = 1'b0;
   endtask

   task automatic test_direction_change();
      load = 1'b1; load_value = 4'd9;
      sb.push_back('{bin: 8'd9, gray: 8'b1101, wrap: 1'b0});
      pop_check("dir_load");
      load = 1'b0; en = 1'b1; up_dn = 1'b1;
      sb.push_back('{bin: 8'd10, gray: 8'b1111, wrap: 1'b0});
      pop_check("dir_up");
      up_dn = 1'b0;
      sb.push_back('{bin: 8'd9, gray: 8'b1101, wrap: 1'b0});
      pop_check("dir_down_9");
      sb.push_back('{bin: 8'd8, gray: 8'b1100, wrap: 1'b0});
      pop_check("dir_down_8");
      en = 1'b0;
   endtask

   task automatic test_sync();
      sync_exp_t e;
      logic [3:0] exp2 [5];
      logic [3:0] exp3 [5];
      exp2 = '{4'd0, 4'd0, 4'd9, 4'd9, 4'd9};
      exp3 = '{4'd0, 4'd0, 4'd0, 4'd9, 4'd9};
      gray_in = 4'b1101;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         sb_sync.push_back('{s2: exp2[k], s3: exp3[k]});
         @(posedge clk);
         #1;
         e = sb_sync.pop_front();
         n_cmp++;
         if (gray_in_bin !== e.s2) begin
            n_fail++;
            $display("FAIL sync2_edge%0d: got %0d expected %0d", k + 1, gray_in_bin, e.s2);
         end
         n_cmp++;
         if (s3_gin_bin !== e.s3) begin
            n_fail++;
            $display("FAIL sync3_edge%0d: got %0d expected %0d", k + 1, s3_gin_bin, e.s3);
         end
      end
   endtask

   task automatic test_async_reset();
      en = 1'b1; up_dn = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         sb.push_back('{bin: 8'(k), gray: 8'(k ^ (k >> 1)), wrap: 1'b0});
         pop_check($sformatf("pre_reset[%0d]", k));
      end
      en = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({bin_out, gray_out, wrap, gray_in_bin, s3_gin_bin} !== 17'h0) begin
         n_fail++;
         $display("FAIL async_reset_midcycle: got %h expected 0",
                  {bin_out, gray_out, wrap, gray_in_bin, s3_gin_bin});
      end
      @(posedge clk);
      #1;
      rst = 1'b0; en = 1'b1; up_dn = 1'b1;
      sb.push_back('{bin: 8'd1, gray: 8'b0001, wrap: 1'b0});
      pop_check("restart");
      en = 1'b0;
   endtask

   task automatic test_wide();
      exp_t e;
      w_load = 1'b1; w_load_value = 8'd255; w_en = 1'b1; w_up_dn = 1'b1;
      sb.push_back('{bin: 8'd255, gray: 8'h80, wrap: 1'b0});
      w_load = 1'b0;
      sb.push_back('{bin: 8'd0, gray: 8'h00, wrap: 1'b1});
      sb.push_back('{bin: 8'd255, gray: 8'h80, wrap: 1'b1});
      for (int k = 0; k < 3; k++) begin
         w_load  = (k == 0);
         w_up_dn = (k != 2);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_cmp++;
         if ({w_bin, w_gray, w_wrap} !== {e.bin, e.gray, e.wrap}) begin
            n_fail++;
            $display("FAIL wide[%0d]: got bin=%0d gray=%b wrap=%b expected bin=%0d gray=%b wrap=%b",
                     k, w_bin, w_gray, w_wrap, e.bin, e.gray, e.wrap);
         end
      end
      w_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_load_hold();
      test_direction_change();
      test_sync();
      test_async_reset();
      test_wide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_ptr_counter.md
Name: gray_ptr_counter

Overview:
Parametrised registered Gray-code counter for use as the read/write pointer of a dual-clock FIFO. It generalises the combinational binary-to-Gray converter into a clocked pointer with enable, up/down counting, synchronous load and a wrap flag. It also includes a multi-stage synchroniser and decoder for a Gray pointer arriving from the opposite clock domain. One instance sits on each side of the FIFO.

Parameters:
PTR, 3, MSB index of pointer; pointer width is PTR+1 bits (default 4 bits, modulo 16).
SYNC_STAGES, 2, number of flops in the gray_in synchroniser chain; legal values are 2 or more.

Ports:
CLK_50M  input  1  counter clock; all registers are rising-edge.
RST  input  1  asynchronous active-high reset.
en  input  1  count enable; one step per cycle while high.
up_dn  input  1  1 = count up, 0 = count down; sampled only when en=1.
load  input  1  synchronous load strobe; has priority over en.
load_value  input  PTR+1  binary value loaded when load=1.
bin_out  output  PTR+1  registered binary pointer.
gray_out  output  PTR+1  registered Gray pointer; always equals bin_out ^ (bin_out>>1).
wrap  output  1  one-cycle pulse registered on a modulo wrap.
gray_in  input  PTR+1  Gray pointer from the other clock domain (asynchronous).
gray_in_bin  output  PTR+1  synchronised gray_in, decoded to binary.

Behaviour:
- Reset (asynchronous on RST=1, independent of clock):
  - bin_out, gray_out, wrap, all synchroniser flops and gray_in_bin go to 0.
  - Outputs hold 0 while RST=1.
  - The first count happens on the first rising edge after RST falls.
- Next-state priority, evaluated per rising edge:
  - load=1: bin_next = load_value.
  - else en=1 and up_dn=1: bin_next = bin_out+1, modulo 2^(PTR+1).
  - else en=1 and up_dn=0: bin_next = bin_out-1, modulo 2^(PTR+1).
  - else: hold.
- gray_out is registered from bin_next ^ (bin_next>>1) on the same edge as bin_out.
  - No combinational path from the count logic to gray_out.
  - Latency from en to gray_out change is 1 cycle.
- Single-bit property: for each count step (not load), gray_out changes in exactly one bit.
- wrap:
  - Set to 1 for one cycle when the step goes from all-ones to 0 (up) or from 0 to all-ones (down).
  - 0 in every other case, including load, hold, and load_value equal to an endpoint.
- Simultaneous load and en: load wins; no count step and no wrap.
- Changing up_dn mid-count takes effect on the next enabled edge; no dead cycle.
- Synchroniser:
  - gray_in passes through SYNC_STAGES flops with no logic between them.
  - The last stage feeds a registered Gray-to-binary decoder: b[PTR]=g[PTR]; b[i]=b[i+1]^g[i].
  - gray_in_bin latency is SYNC_STAGES+1 cycles from a stable gray_in.
  - There is no decode before the final synchroniser stage.
- Width:
  - All arithmetic is PTR+1 bits unsigned.
  - Overflow and underflow discard the carry.
  - No saturation.

Test Plan:
- PTR=3, reset, en=1, up_dn=1 for 16 cycles: gray_out follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000. wrap pulses exactly once, on the 15→0 step. Each step changes one bit of gray_out.
- From reset, en=1, up_dn=0: bin_out goes to 15 and gray_out to 1000 after one edge, with wrap=1 for that cycle. Next values are 14/1001 with wrap=0.
- load=1, load_value=9, en=1 in the same cycle: bin_out=9 and gray_out=1101 after one edge, wrap=0. Then en=0 for 5 cycles: outputs hold 9/1101.
- Hold gray_in=1101 stable with SYNC_STAGES=2: gray_in_bin=0 for the first 2 edges and 9 on the 3rd edge. Repeat with SYNC_STAGES=3: gray_in_bin=9 on the 4th edge.
- Count up to 6, then assert RST between clock edges: bin_out, gray_out, wrap and gray_in_bin go to 0 immediately, before the next edge. After RST falls, counting restarts at 1/0001.
- PTR=7, load 255, en=1, up_dn=1: bin_out=0 and gray_out=0 with wrap=1. Then up_dn=0: bin_out=255, gray_out=10000000, wrap=1.
